uart_tx_arbiter: RTL and testbench

- Shares one uart_tx serializer between NUM_REQ byte sources.
- Uses round-robin arbitration with optional frame lock: a requester keeps the grant until it marks its last byte.
- Issues one-cycle o_Tx_DV pulses to uart_tx and sequences on its i_Tx_Done/i_Tx_Active outputs.
- Sits between the device-side byte producers and uart_tx.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/rr_pick.sv | 43 ++++
 rtl/uart_tx_arbiter.sv | 158 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART definitions: arbiter state encoding and byte width.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        GUARD     = 2'd3
    } arb_state_t;

    localparam int UART_BYTE_W  = 8;
    localparam int CLKS_PER_BIT = 87;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker, search starts at ptr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0] w_rot;
    int           w_k;

    // Rotate so that bit 0 is the requester at ptr, then take the first set bit.
    assign w_rot = N'({valid, valid} >> ptr);

    always_comb begin
        winner = '0;
        idx    = '0;
        any    = 1'b0;
        w_k    = 0;
        for (int i = 0; i < N; i++) begin
            if (!any && (((w_rot >> i) & N'(1)) != '0)) begin
                w_k = int'(ptr) + i;
                if (w_k >= N) w_k = w_k - N;
                winner = N'(1) << w_k;
                idx    = IW'(w_k);
                any    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin sharing of one uart_tx among NUM_REQ byte sources,
//            with frame lock, lock timeout and hung-serializer re-issue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_FRAME    = 16,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic                           i_Clock,
    input  logic                           i_Rst_L,
    input  logic [NUM_REQ-1:0]             i_Req_Valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] i_Req_Data,
    input  logic [NUM_REQ-1:0]             i_Req_Last,
    output logic [NUM_REQ-1:0]             o_Req_Ready,
    output logic [NUM_REQ-1:0]             o_Grant,
    output logic                           o_Busy,
    output logic                           o_Tx_DV,
    output logic [UART_BYTE_W-1:0]         o_Tx_Byte,
    input  logic                           i_Tx_Active,
    input  logic                           i_Tx_Done
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int FW = $clog2(MAX_FRAME + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    arb_state_t    r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_owner;
    logic          r_lock;
    logic          r_last;
    logic          r_retry;
    logic [1:0]    r_wait_cnt;
    logic [FW-1:0] r_frame_cnt;
    logic [TW-1:0] r_to_cnt;

    logic [NUM_REQ-1:0]     w_win_onehot;
    logic [IW-1:0]          w_win_idx;
    logic                   w_win_any;
    logic [IW-1:0]          w_sel_idx;
    logic [NUM_REQ-1:0]     w_sel_onehot;
    logic [UART_BYTE_W-1:0] w_sel_byte;
    logic                   w_sel_last;
    logic                   w_own_valid;
    logic [IW-1:0]          w_ptr_next;
    logic [FW-1:0]          w_frame_inc;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .valid  (i_Req_Valid),
        .ptr    (r_ptr),
        .winner (w_win_onehot),
        .idx    (w_win_idx),
        .any    (w_win_any)
    );

    // While locked the owner is the only candidate; otherwise the rr winner.
    assign w_sel_idx    = r_lock ? r_owner : w_win_idx;
    assign w_sel_onehot = r_lock ? o_Grant : w_win_onehot;
    assign w_sel_byte   = UART_BYTE_W'(i_Req_Data >> {w_sel_idx, 3'b000});
    assign w_sel_last   = |(i_Req_Last & w_sel_onehot);
    assign w_own_valid  = |(i_Req_Valid & o_Grant);
    assign w_ptr_next   = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + IW'(1);
    assign w_frame_inc  = r_frame_cnt + FW'(1);

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_lock      <= 1'b0;
            r_last      <= 1'b0;
            r_retry     <= 1'b0;
            r_wait_cnt  <= '0;
            r_frame_cnt <= '0;
            r_to_cnt    <= '0;
            o_Req_Ready <= '0;
            o_Grant     <= '0;
            o_Busy      <= 1'b0;
            o_Tx_DV     <= 1'b0;
            o_Tx_Byte   <= '0;
        end else begin
            o_Tx_DV     <= 1'b0;
            o_Req_Ready <= '0;
            case (r_state)
                IDLE: begin
                    if ((!r_lock && w_win_any) || (r_lock && w_own_valid)) begin
                        if (!r_lock) begin
                            o_Grant <= w_win_onehot;
                            r_owner <= w_win_idx;
                        end
                        o_Req_Ready <= w_sel_onehot;
                        o_Tx_DV     <= 1'b1;
                        o_Tx_Byte   <= w_sel_byte;
                        o_Busy      <= 1'b1;
                        r_last      <= w_sel_last;
                        r_to_cnt    <= '0;
                        r_state     <= ISSUE;
                    end else if (r_lock) begin
                        if (r_to_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                            r_lock      <= 1'b0;
                            o_Grant     <= '0;
                            r_ptr       <= w_ptr_next;
                            r_to_cnt    <= '0;
                            r_frame_cnt <= '0;
                        end else begin
                            r_to_cnt <= r_to_cnt + TW'(1);
                        end
                    end
                end
                ISSUE: begin
                    // A re-issue of the same byte must not count as a new frame byte.
                    if (!r_retry) begin
                        r_frame_cnt <= w_frame_inc;
                        r_lock      <= !r_last && (w_frame_inc < FW'(MAX_FRAME));
                    end
                    r_retry    <= 1'b0;
                    r_wait_cnt <= '0;
                    r_state    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (i_Tx_Done) begin
                        r_state <= GUARD;
                    end else if (r_wait_cnt == 2'd1 && !i_Tx_Active) begin
                        o_Tx_DV <= 1'b1;
                        r_retry <= 1'b1;
                        r_state <= ISSUE;
                    end
                    if (r_wait_cnt != 2'd2) r_wait_cnt <= r_wait_cnt + 2'd1;
                end
                GUARD: begin
                    if (!i_Tx_Done) begin
                        o_Busy  <= 1'b0;
                        r_state <= IDLE;
                        if (!r_lock) begin
                            r_ptr       <= w_ptr_next;
                            r_frame_cnt <= '0;
                            o_Grant     <= '0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed bench with a small uart_tx model (4 clocks per bit).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int CPB = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid, req_last, req_ready, grant;
    logic [31:0] req_data;
    logic        busy, tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active = 1'b0;
    logic        tx_done   = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .MAX_FRAME    (4),
        .LOCK_TIMEOUT (8)
    ) dut (
        .i_Clock     (clk),
        .i_Rst_L     (rst_n),
        .i_Req_Valid (req_valid),
        .i_Req_Data  (req_data),
        .i_Req_Last  (req_last),
        .o_Req_Ready (req_ready),
        .o_Grant     (grant),
        .o_Busy      (busy),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done)
    );

    always #5 clk = ~clk;

    // Requester byte queues: {last, data}, valid while non-empty.
    logic [8:0] qmem [4][64];
    int qh [4] = '{default: 0};
    int qt [4] = '{default: 0};

    for (genvar k = 0; k < 4; k++) begin : g_req
        assign req_valid[k]         = (qh[k] != qt[k]);
        assign req_data[8*k +: 8]   = qmem[k][qh[k] % 64][7:0];
        assign req_last[k]          = qmem[k][qh[k] % 64][8];
    end

    always @(posedge clk)
        for (int k = 0; k < 4; k++)
            if (req_ready[k]) qh[k] <= qh[k] + 1;

    // Log of every o_Tx_DV pulse and per-requester ready counts.
    int         lg_own [256];
    logic [7:0] lg_byte [256];
    int         lg_n = 0;
    int         rdy_cnt [4] = '{default: 0};

    function automatic int oh_idx(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(posedge clk) begin
        if (tx_dv) begin
            lg_own[lg_n % 256]  <= oh_idx(grant);
            lg_byte[lg_n % 256] <= tx_byte;
            lg_n                <= lg_n + 1;
        end
        for (int k = 0; k < 4; k++)
            if (req_ready[k]) rdy_cnt[k] <= rdy_cnt[k] + 1;
    end

    // uart_tx model: not reset by the arbiter reset; done high for 2 cycles.
    int         m_cnt   = -1;
    logic [9:0] m_frame = 10'h3FF;
    logic       m_en    = 1'b1;
    logic       tx_serial;
    logic [7:0] rx_byte = 8'h00;

    assign tx_serial = (m_cnt >= 0 && m_cnt < 10*CPB) ? m_frame[m_cnt/CPB] : 1'b1;

    always @(posedge clk) begin
        tx_done <= 1'b0;
        if (m_cnt < 0) begin
            if (tx_dv && m_en) begin
                m_frame   <= {1'b1, tx_byte, 1'b0};
                m_cnt     <= 0;
                tx_active <= 1'b1;
            end
        end else if (m_cnt < 10*CPB - 1) begin
            m_cnt <= m_cnt + 1;
        end else if (m_cnt == 10*CPB - 1) begin
            m_cnt     <= 10*CPB;
            tx_active <= 1'b0;
            tx_done   <= 1'b1;
        end else begin
            tx_done <= 1'b1;
            m_cnt   <= -1;
        end
        if (m_cnt >= CPB && m_cnt < 9*CPB && (m_cnt % CPB) == CPB/2)
            rx_byte[m_cnt/CPB - 1] <= tx_serial;
    end

    task automatic push(input int k, input logic last, input logic [7:0] d);
        qmem[k][qt[k] % 64] = {last, d};
        qt[k] = qt[k] + 1;
    endtask

    task automatic flush();
        for (int k = 0; k < 4; k++) qt[k] = qh[k];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_log(input int n, input bit need_idle, input int budget, input string tag);
        int c = 0;
        while (!(lg_n >= n && (!need_idle || !busy)) && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: timeout, tx pulses got %0d want %0d busy=%0b", tag, lg_n, n, busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0000) begin
            n_bad++; $display("FAIL reset_grant: got %b want 0000", grant);
        end
        n_cmp++;
        if ({busy, tx_dv, tx_byte, req_ready} !== 14'h0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", {busy, tx_dv, tx_byte, req_ready});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_byte();
        int base = lg_n;
        int r1   = rdy_cnt[1];
        @(negedge clk);
        push(1, 1'b1, 8'hA5);
        @(negedge clk);
        n_cmp++;
        if ({tx_dv, grant, req_ready, tx_byte} !== {1'b1, 4'b0010, 4'b0010, 8'hA5}) begin
            n_bad++; $display("FAIL single_issue: got %h want %h",
                              {tx_dv, grant, req_ready, tx_byte}, {1'b1, 4'b0010, 4'b0010, 8'hA5});
        end
        wait_log(base + 1, 1'b1, 200, "single_wait");
        n_cmp++;
        if ({busy, grant} !== 5'b0) begin
            n_bad++; $display("FAIL single_idle: busy/grant got %b want 00000", {busy, grant});
        end
        n_cmp++;
        if (rdy_cnt[1] - r1 != 1) begin
            n_bad++; $display("FAIL single_ready: got %0d want 1", rdy_cnt[1] - r1);
        end
        n_cmp++;
        if (rx_byte !== 8'hA5) begin
            n_bad++; $display("FAIL single_serial: got %h want a5", rx_byte);
        end
    endtask

    task automatic test_round_robin();
        int base;
        int r0 [4];
        do_reset();
        base = lg_n;
        for (int k = 0; k < 4; k++) r0[k] = rdy_cnt[k];
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 3; j++) push(k, 1'b1, 8'(16*k + j));
        wait_log(base + 5, 1'b1, 600, "rr_wait");
        flush();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (lg_own[(base+i) % 256] != i % 4 || lg_byte[(base+i) % 256] !== 8'(16*(i%4) + i/4)) begin
                n_bad++; $display("FAIL rr_order[%0d]: got req%0d byte %h want req%0d byte %h", i,
                                  lg_own[(base+i) % 256], lg_byte[(base+i) % 256], i % 4, 8'(16*(i%4) + i/4));
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (rdy_cnt[k] - r0[k] != ((k == 0) ? 2 : 1)) begin
                n_bad++; $display("FAIL rr_ready[%0d]: got %0d want %0d", k, rdy_cnt[k] - r0[k], (k == 0) ? 2 : 1);
            end
        end
    endtask

    task automatic test_frame_lock();
        int         base = lg_n;
        int         eo [4] = '{2, 2, 2, 0};
        logic [7:0] eb [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        push(2, 1'b0, 8'h11); push(2, 1'b0, 8'h22); push(2, 1'b1, 8'h33);
        push(0, 1'b1, 8'h44); push(0, 1'b1, 8'h45);
        wait_log(base + 4, 1'b1, 600, "lock_wait");
        flush();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (lg_own[(base+i) % 256] != eo[i] || lg_byte[(base+i) % 256] !== eb[i]) begin
                n_bad++; $display("FAIL lock_order[%0d]: got req%0d byte %h want req%0d byte %h", i,
                                  lg_own[(base+i) % 256], lg_byte[(base+i) % 256], eo[i], eb[i]);
            end
        end
    endtask

    task automatic test_max_frame();
        int         base = lg_n;
        int         eo [5] = '{3, 3, 3, 3, 1};
        logic [7:0] eb [5] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h9A};
        for (int j = 0; j < 6; j++) push(3, 1'b0, 8'(8'h30 + j));
        wait_log(base + 1, 1'b0, 100, "maxf_first");
        push(1, 1'b1, 8'h9A);
        wait_log(base + 5, 1'b1, 600, "maxf_wait");
        flush();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (lg_own[(base+i) % 256] != eo[i] || lg_byte[(base+i) % 256] !== eb[i]) begin
                n_bad++; $display("FAIL maxf_order[%0d]: got req%0d byte %h want req%0d byte %h", i,
                                  lg_own[(base+i) % 256], lg_byte[(base+i) % 256], eo[i], eb[i]);
            end
        end
    endtask

    task automatic test_lock_timeout();
        int base;
        do_reset();
        base = lg_n;
        push(0, 1'b0, 8'h01);
        wait_log(base + 1, 1'b1, 200, "to_first");
        push(2, 1'b1, 8'h77);
        repeat (7) @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0001) begin
            n_bad++; $display("FAIL to_held: grant got %b want 0001", grant);
        end
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0000) begin
            n_bad++; $display("FAIL to_release: grant got %b want 0000", grant);
        end
        @(negedge clk);
        n_cmp++;
        if ({grant, tx_dv, tx_byte} !== {4'b0100, 1'b1, 8'h77}) begin
            n_bad++; $display("FAIL to_regrant: got %h want %h", {grant, tx_dv, tx_byte}, {4'b0100, 1'b1, 8'h77});
        end
        wait_log(base + 2, 1'b1, 200, "to_wait");
        n_cmp++;
        if (rx_byte !== 8'h77) begin
            n_bad++; $display("FAIL to_serial: got %h want 77", rx_byte);
        end
    endtask

    task automatic test_reset_mid();
        int base = lg_n;
        push(1, 1'b1, 8'hB1);
        wait_log(base + 1, 1'b0, 100, "rmid_first");
        repeat (5) @(negedge clk);
        push(0, 1'b1, 8'hD0); push(1, 1'b1, 8'hD1); push(2, 1'b1, 8'hD2); push(3, 1'b1, 8'hD3);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({grant, busy, tx_dv, tx_byte, req_ready} !== 18'h0) begin
            n_bad++; $display("FAIL rmid_zero: got %h want 0", {grant, busy, tx_dv, tx_byte, req_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0001) begin
            n_bad++; $display("FAIL rmid_first_grant: got %b want 0001", grant);
        end
        @(negedge clk);
        flush();
        wait_log(base + 2, 1'b1, 300, "rmid_wait");
    endtask

    task automatic test_hung();
        int base = lg_n;
        int r3   = rdy_cnt[3];
        int c    = 0;
        m_en = 1'b0;
        push(3, 1'b1, 8'hE7);
        while (tx_dv !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({tx_dv, tx_byte, req_ready} !== {1'b1, 8'hE7, 4'b0000}) begin
            n_bad++; $display("FAIL hung_repulse: got %h want %h", {tx_dv, tx_byte, req_ready}, {1'b1, 8'hE7, 4'b0000});
        end
        m_en = 1'b1;
        wait_log(base + 2, 1'b1, 300, "hung_wait");
        n_cmp++;
        if (rdy_cnt[3] - r3 != 1) begin
            n_bad++; $display("FAIL hung_ready: got %0d want 1", rdy_cnt[3] - r3);
        end
        n_cmp++;
        if (rx_byte !== 8'hE7) begin
            n_bad++; $display("FAIL hung_serial: got %h want e7", rx_byte);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_frame_lock();
        test_max_frame();
        test_lock_timeout();
        test_reset_mid();
        test_hung();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
